quad_decoder: RTL and testbench

- Quadrature (A/B) position decoder: the receive end of an incremental encoder interface.
- Synchronises the two asynchronous phase inputs and decodes Gray-code transitions into up/down steps.
- Drives an up/down position counter with direction, step, wrap and error status.
- Sits between external encoder pins and the control logic that consumes position.

---
 rtl/quad_decoder.sv | 163 ++++++++++++++++
 tb/tb_quad_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronised phases, Gray-step decode, wrapping up/down position count.
// Optional GLITCH_FILTER_EN adds a FILT_LEN-sample majority-free stability filter per phase.
module quad_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 2) begin : g_bad_filt
    $error("FILT_LEN must be at least 2");
  end

`ifdef GLITCH_FILTER_EN
  localparam int FILL = SYNC_STAGES + FILT_LEN;
`else
  localparam int FILL = SYNC_STAGES;
`endif
  localparam int FW = $clog2(FILL + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   primed_q, primed_d;
  logic [1:0]             prev_q, prev_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   dir_q, dir_d, step_q, step_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  logic                   a_s, b_s, filled;
  logic [1:0]             cur, diff;

  assign a_s    = a_sync_q[SYNC_STAGES-1];
  assign b_s    = b_sync_q[SYNC_STAGES-1];
  assign filled = (fill_q == FW'(FILL));
  assign fill_d = filled ? fill_q : fill_q + FW'(1);

`ifdef GLITCH_FILTER_EN
  // Window is the current synced sample plus FILT_LEN-1 history bits; output moves only when all agree.
  logic [FILT_LEN-2:0] a_hist_q, b_hist_q;
  logic [FILT_LEN-1:0] a_win, b_win;
  logic                a_filt_q, b_filt_q, a_filt_d, b_filt_d;

  assign a_win    = {a_hist_q, a_s};
  assign b_win    = {b_hist_q, b_s};
  assign a_filt_d = (&a_win) ? 1'b1 : ((|a_win) ? a_filt_q : 1'b0);
  assign b_filt_d = (&b_win) ? 1'b1 : ((|b_win) ? b_filt_q : 1'b0);
  assign cur      = {a_filt_d, b_filt_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hist_q <= '0;
      b_hist_q <= '0;
      a_filt_q <= 1'b0;
      b_filt_q <= 1'b0;
    end else begin
      a_hist_q <= a_win[FILT_LEN-2:0];
      b_hist_q <= b_win[FILT_LEN-2:0];
      a_filt_q <= a_filt_d;
      b_filt_q <= b_filt_d;
    end
  end
`else
  assign cur = {a_s, b_s};
`endif

  // Gray state to position index: 00->0, 01->1, 11->2, 10->3; index delta gives direction.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign diff = gray_pos(cur) - gray_pos(prev_q);

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    count_d  = count_q;
    dir_d    = dir_q;
    err_d    = err_q;
    step_d   = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
      if (filled) begin
        prev_d   = cur;
        primed_d = 1'b1;
      end
    end else if (!primed_q) begin
      if (filled) begin
        prev_d   = cur;
        primed_d = 1'b1;
      end
    end else begin
      prev_d = cur;
      case (diff)
        2'd1: begin
          step_d  = 1'b1;
          dir_d   = 1'b1;
          ovf_d   = &count_q;
          count_d = count_q + WIDTH'(1);
        end
        2'd3: begin
          step_d  = 1'b1;
          dir_d   = 1'b0;
          unf_d   = ~|count_q;
          count_d = count_q - WIDTH'(1);
        end
        2'd2:    err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      prev_q   <= 2'b00;
      count_q  <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
      fill_q   <= fill_d;
      primed_q <= primed_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: priming, stepping, wrap, illegal jumps, clr priority, async reset.
module tb_quad_decoder;

`ifdef GLITCH_FILTER_EN
  localparam int LAT = 2 + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b1;
  logic       enc_b = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] count;
  logic       dir, step, ovf, unf, err;

  int errors = 0;
  int checks = 0;
  int step_cnt = 0;
  int base;

  quad_decoder #(.WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .clr   (clr),
    .count (count),
    .dir   (dir),
    .step  (step),
    .ovf   (ovf),
    .unf   (unf),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) step_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    {enc_a, enc_b} = ab;
  endtask

  initial begin
    // Reset with encoder resting at 11
    tick(3);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {27'd0, dir, step, ovf, unf, err}, 0);
    rst = 1'b0;
    base = step_cnt;
    tick(10);
    chk("prime11_count", 32'(count), 0);
    chk("prime11_steps", 32'(step_cnt - base), 0);
    chk("prime11_err", 32'(err), 0);

    // Re-reset at 00 to start the up sequence
    set_ab(2'b00);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    base = step_cnt;
    set_ab(2'b01);
    tick(LAT - 1);
    chk("lat_early_step", 32'(step), 0);
    tick(1);
    chk("lat_step", 32'(step), 1);
    chk("lat_count", 32'(count), 1);
    tick(5);
    set_ab(2'b11); tick(8);
    set_ab(2'b10); tick(8);
    set_ab(2'b00); tick(8);
    chk("up4_count", 32'(count), 4);
    chk("up4_dir", 32'(dir), 1);
    chk("up4_steps", 32'(step_cnt - base), 4);

    // Clear, then wrap down and back up
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_count", 32'(count), 0);
    chk("clr_dir_kept", 32'(dir), 1);
    set_ab(2'b10);
    tick(LAT);
    chk("unf_count", 32'(count), 255);
    chk("unf_pulse", {29'd0, step, unf, ovf}, 32'b110);
    chk("unf_dir", 32'(dir), 0);
    tick(1);
    chk("unf_one_cycle", {30'd0, step, unf}, 0);
    tick(4);
    set_ab(2'b00);
    tick(LAT);
    chk("ovf_count", 32'(count), 0);
    chk("ovf_pulse", {29'd0, step, unf, ovf}, 32'b101);
    chk("ovf_dir", 32'(dir), 1);
    tick(5);

    // Illegal jump 00->11, then legal 11->10
    base = step_cnt;
    set_ab(2'b11); tick(8);
    chk("ill_err", 32'(err), 1);
    chk("ill_count", 32'(count), 0);
    chk("ill_steps", 32'(step_cnt - base), 0);
    set_ab(2'b10); tick(8);
    chk("ill_resync_count", 32'(count), 1);
    chk("ill_err_sticky", 32'(err), 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_err", 32'(err), 0);
    chk("clr_count2", 32'(count), 0);

    // clr coincident with an arriving step swallows it
    base = step_cnt;
    set_ab(2'b00);
    tick(LAT - 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_coinc_count", 32'(count), 0);
    chk("clr_coinc_step", 32'(step), 0);
    tick(5);
    chk("clr_coinc_steps", 32'(step_cnt - base), 0);
    set_ab(2'b01); tick(8);
    chk("after_clr_count", 32'(count), 1);
    chk("after_clr_dir", 32'(dir), 1);

    // Asynchronous reset mid-operation, then re-prime at 01
    #3 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    tick(2);
    rst = 1'b0;
    base = step_cnt;
    tick(10);
    chk("reprime_count", 32'(count), 0);
    chk("reprime_steps", 32'(step_cnt - base), 0);

`ifdef GLITCH_FILTER_EN
    base = step_cnt;
    set_ab(2'b11); tick(2);
    set_ab(2'b01); tick(12);
    chk("glitch_steps", 32'(step_cnt - base), 0);
    chk("glitch_count", 32'(count), 0);
    set_ab(2'b11);
    tick(LAT - 1);
    chk("filt_early_step", 32'(step), 0);
    tick(1);
    chk("filt_step", 32'(step), 1);
    chk("filt_count", 32'(count), 1);
    tick(5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
